// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer front-end.
// No logic; constants and typedefs only.
// Defaults match the FC layer geometry (8-bit activations, 400 inputs).
package fc_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int IN_DEF    = 400;
  localparam int IDX_W     = $clog2(IN_DEF);

  typedef logic [WIDTH_DEF-1:0] act_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } ld_state_e;

endpackage

// File: rtl/fc_act_loader.sv
// Assembles IN streamed activations into a parallel vector for the FC layer; rejects bad-length frames.
// Latency: x_valid rises the cycle after the last good beat; err_len pulses the cycle after a length error.
// Backpressure: s_ready drops while a vector is held (HOLD) until x_ack; upstream must hold its beat.
module fc_act_loader
  import fc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IN    = IN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ack,
  output logic             err_len,
  output logic [CNT_W-1:0] frame_cnt
);

  // A one-entry frame still needs a 1-bit index register.
  localparam int LIDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(IN - 1);

  ld_state_e state, state_nx;
  logic [LIDX_W-1:0] idx;
  logic acc;
  logic fill_acc;
  logic at_last;

  assign acc      = s_valid & s_ready;
  assign fill_acc = acc & (state == FILL);
  assign at_last  = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  // Next-state decode: length check happens on the beat that lands in the final slot
  always_comb begin
    state_nx = state;
    case (state)
      FILL: begin
        if (fill_acc && at_last) state_nx = s_last ? HOLD : DRAIN;
      end
      DRAIN: begin
        if (acc && s_last) state_nx = FILL;
      end
      HOLD: begin
        if (x_ack) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Outputs: ready everywhere except HOLD, and never while reset is asserted
  always_comb begin
    s_ready = 1'b0;
    x_valid = 1'b0;
    case (state)
      FILL:    s_ready = rst_n;
      DRAIN:   s_ready = rst_n;
      HOLD:    x_valid = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // Write index: advances on accepted FILL beats, restarts on any frame end or error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (state != FILL) begin
      idx <= '0;
    end else if (fill_acc) begin
      if (at_last || s_last) idx <= '0;
      else                   idx <= idx + LIDX_W'(1);
    end
  end

  // Vector buffer: only FILL beats write, so HOLD and DRAIN leave x untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN; i++) x[i] <= '0;
    end else if (fill_acc) begin
      x[idx] <= s_data;
    end
  end

  // Length error pulse: early s_last (short) or missing s_last at the final slot (long)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_len <= 1'b0;
    else        err_len <= fill_acc & (at_last ? !s_last : s_last);
  end

  // Good-frame counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           frame_cnt <= '0;
    else if (fill_acc && at_last && s_last) frame_cnt <= frame_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fc_act_loader.sv
// Directed bench for fc_act_loader: good, short, long, gapped and reset-interrupted frames.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every wait on s_ready is bounded.
module tb_fc_act_loader;

  localparam int W  = 8;
  localparam int N  = 400;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [W-1:0]  x [0:N-1];
  logic          x_valid;
  logic          x_ack = 1'b0;
  logic          err_len;
  logic [CW-1:0] frame_cnt;

  int nchk = 0;
  int nerr = 0;
  logic [W-1:0]  pat [0:N+9];
  logic [W-1:0]  snap [0:N-1];
  logic [CW-1:0] exp_cnt = '0;

  fc_act_loader #(.WIDTH(W), .IN(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .x(x), .x_valid(x_valid), .x_ack(x_ack),
    .err_len(err_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns on the falling edge after acceptance.
  task automatic beat(input logic [W-1:0] d, input logic l, input bit gaps);
    int n;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    s_data = d; s_last = l; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Send pat[lo..hi]; s_last on index last_at (negative = never).
  task automatic send_range(input int lo, input int hi, input int last_at, input bit gaps);
    for (int i = lo; i <= hi; i++) beat(pat[i], (i == last_at), gaps);
  endtask

  task automatic check_vec(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (x[i] !== pat[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (x[i] !== '0) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic ack_frame();
    x_ack = 1'b1;
    @(negedge clk);
    x_ack = 1'b0;
  endtask

  task automatic good_frame(input string tag, input int seed);
    for (int i = 0; i < N; i++) pat[i] = W'(i * seed + 3);
    send_range(0, N - 2, -1, 1'b0);
    chk({tag, "_xv_pre"}, 32'(x_valid), 32'd0);
    beat(pat[N-1], 1'b1, 1'b0);
    exp_cnt++;
    chk({tag, "_xv"}, 32'(x_valid), 32'd1);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check_vec({tag, "_vec"});
    ack_frame();
    chk({tag, "_xv_fall"}, 32'(x_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_xv", 32'(x_valid), 32'd0);
    chk("rst_rdy", 32'(s_ready), 32'd0);
    chk("rst_err", 32'(err_len), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    check_zero("rst_x");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(s_ready), 32'd1);

    // 1: first good frame, data = i % 256
    for (int i = 0; i < N; i++) pat[i] = W'(i);
    send_range(0, N - 2, -1, 1'b0);
    beat(pat[N-1], 1'b1, 1'b0);
    exp_cnt++;
    chk("t1_xv", 32'(x_valid), 32'd1);
    chk("t1_x0", 32'(x[0]), 32'h00);
    chk("t1_x255", 32'(x[255]), 32'hFF);
    chk("t1_x256", 32'(x[256]), 32'h00);
    chk("t1_x399", 32'(x[399]), 32'h8F);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_rdy_hold", 32'(s_ready), 32'd0);

    // 2: beats offered during HOLD must not be consumed or written
    for (int i = 0; i < N; i++) snap[i] = x[i];
    s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0 || c == 9) chk("t2_rdy_hold", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < N; i++) if (x[i] !== snap[i]) bad++;
      chk("t2_frozen", 32'(bad), 32'd0);
    end
    chk("t2_cnt_hold", 32'(frame_cnt), 32'd1);
    ack_frame();
    chk("t2_xv_fall", 32'(x_valid), 32'd0);
    chk("t2_rdy_back", 32'(s_ready), 32'd1);
    for (int i = 0; i < N; i++) pat[i] = W'(i * 3 + 1);
    send_range(0, 0, -1, 1'b0);
    chk("t2_next_x0", 32'(x[0]), 32'h01);
    send_range(1, N - 1, N - 1, 1'b0);
    exp_cnt++;
    chk("t2_xv", 32'(x_valid), 32'd1);
    check_vec("t2_vec");
    ack_frame();

    // 3: short frame (s_last on beat 100)
    for (int i = 0; i < N; i++) pat[i] = W'(8'h40 + i);
    send_range(0, 100, 100, 1'b0);
    chk("t3_err", 32'(err_len), 32'd1);
    chk("t3_xv", 32'(x_valid), 32'd0);
    @(negedge clk);
    chk("t3_err_1cyc", 32'(err_len), 32'd0);
    chk("t3_cnt", 32'(frame_cnt), 32'(exp_cnt));
    good_frame("t3_good", 5);

    // 4: long frame of 405 beats, s_last only on beat 404
    for (int i = 0; i < N + 5; i++) pat[i] = W'(i + 17);
    send_range(0, N - 1, -1, 1'b0);
    chk("t4_err", 32'(err_len), 32'd1);
    chk("t4_xv", 32'(x_valid), 32'd0);
    begin
      logic [W-1:0] x0_save;
      x0_save = x[0];
      send_range(N, N, -1, 1'b0);
      chk("t4_err_1cyc", 32'(err_len), 32'd0);
      send_range(N + 1, N + 4, N + 4, 1'b0);
      chk("t4_x0_kept", 32'(x[0]), 32'(x0_save));
    end
    chk("t4_xv_after", 32'(x_valid), 32'd0);
    chk("t4_cnt", 32'(frame_cnt), 32'(exp_cnt));
    good_frame("t4_good", 7);

    // 5: random gaps in s_valid, random data
    for (int i = 0; i < N; i++) pat[i] = W'($urandom);
    send_range(0, N - 2, -1, 1'b1);
    chk("t5_xv_pre", 32'(x_valid), 32'd0);
    beat(pat[N-1], 1'b1, 1'b1);
    exp_cnt++;
    chk("t5_xv", 32'(x_valid), 32'd1);
    check_vec("t5_vec");
    ack_frame();

    // 6a: reset mid-frame at beat 200
    for (int i = 0; i < N; i++) pat[i] = W'(i + 99);
    send_range(0, 199, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6a_xv", 32'(x_valid), 32'd0);
    chk("t6a_cnt", 32'(frame_cnt), 32'd0);
    chk("t6a_rdy", 32'(s_ready), 32'd0);
    check_zero("t6a_x");
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6a_err", 32'(err_len), 32'd0);
    good_frame("t6a_good", 11);

    // 6b: reset while holding a frame
    for (int i = 0; i < N; i++) pat[i] = W'(i * 13);
    send_range(0, N - 1, N - 1, 1'b0);
    chk("t6b_hold", 32'(x_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_xv", 32'(x_valid), 32'd0);
    chk("t6b_cnt", 32'(frame_cnt), 32'd0);
    check_zero("t6b_x");
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6b_err", 32'(err_len), 32'd0);
    chk("t6b_rdy", 32'(s_ready), 32'd1);
    good_frame("t6b_good", 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
